// File: rtl/matrix_loader_if.sv
// Stream and result bus between the matrix loader and its neighbours.
// The producer side pushes signed elements in. The consumer side takes the
// packed matrix and its size code.
interface matrix_loader_if #(
  parameter int ELEM_W    = 8,
  parameter int MAX_ELEMS = 25
);
  logic                          in_valid;
  logic                          in_ready;
  logic [ELEM_W-1:0]             in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [ELEM_W*MAX_ELEMS-1:0]   matrix_out;
  logic [1:0]                    matrix_size;

  // Environment view: drives elements and the downstream ready
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, matrix_out, matrix_size
  );

  // Loader view: accepts elements and presents the packed matrix
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, matrix_out, matrix_size
  );
endinterface

// File: rtl/matrix_loader.sv
// Input staging buffer for the matrix coprocessor.
// Collects 4/9/16/25 signed bytes row-major into a 200-bit operand bus.
// Holds the packed matrix until the downstream stage takes it.
module matrix_loader #(
  parameter int ELEM_W    = 8,
  parameter int MAX_ELEMS = 25
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         size_in,
  input  logic               abort,
  output logic               busy,
  matrix_loader_if.slave     bus
);

  localparam int BUS_W = ELEM_W * MAX_ELEMS;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [4:0]         idx;
  logic [4:0]         count;
  logic [BUS_W-1:0]   matrix_q;
  logic [1:0]         size_q;
  logic               accept;
  logic               last_elem;

  // Element count for each size code
  function automatic logic [4:0] count_for(input logic [1:0] code);
    case (code)
      2'b00:   count_for = 5'd4;
      2'b01:   count_for = 5'd9;
      2'b10:   count_for = 5'd16;
      default: count_for = 5'd25;
    endcase
  endfunction

  assign accept    = (state == LOAD) && bus.in_valid && !abort;
  assign last_elem = (idx == (count - 5'd1));

  // All handshake outputs decode from registered state only
  assign bus.in_ready    = (state == LOAD);
  assign bus.out_valid   = (state == HOLD);
  assign busy            = (state != IDLE);
  assign bus.matrix_out  = matrix_q;
  assign bus.matrix_size = size_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode. Abort wins over an accept; start is only seen in IDLE
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        if (abort)                       next_state = IDLE;
        else if (accept && last_elem)    next_state = HOLD;
      end
      HOLD: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: latch size, clear on start/abort, write accepted elements
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= 5'd0;
      count    <= 5'd0;
      matrix_q <= '0;
      size_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            size_q   <= size_in;
            count    <= count_for(size_in);
            matrix_q <= '0;
            idx      <= 5'd0;
          end
        end
        LOAD: begin
          if (abort) begin
            matrix_q <= '0;
            idx      <= 5'd0;
          end else if (accept) begin
            for (int i = 0; i < MAX_ELEMS; i++) begin
              if (idx == 5'(i)) matrix_q[i*ELEM_W +: ELEM_W] <= bus.in_data;
            end
            idx <= last_elem ? 5'd0 : idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader.
// Inputs change 1ns after each rising edge, and outputs are sampled there.
module tb_matrix_loader;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   size_in;
  logic         abort;
  logic         busy;
  int           compared;
  int           mismatched;
  logic [199:0] exp_mat;
  int           k;
  logic         early;
  logic         v;

  matrix_loader_if #(.ELEM_W(8), .MAX_ELEMS(25)) bus ();

  matrix_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .size_in (size_in),
    .abort   (abort),
    .busy    (busy),
    .bus     (bus.slave)
  );

  // Free-running 10ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [199:0] got, input logic [199:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, cross the rising edge, settle 1ns
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic ab,
                               input logic vld, input logic [7:0] d, input logic ordy);
    start         = st;
    size_in       = sz;
    abort         = ab;
    bus.in_valid  = vld;
    bus.in_data   = d;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    size_in       = 2'b00;
    abort         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 0, 8'h00, 0);
    checkOutput("rst_in_ready", bus.in_ready, 0);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_matrix", bus.matrix_out, 0);
    checkOutput("rst_size", bus.matrix_size, 0);

    // Reset during a 3x3 load after 3 elements
    applyStimulus(1, 2'b01, 0, 0, 8'h00, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, 0, 1, 8'(8'h41 + i), 0);
    checkOutput("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", bus.in_ready, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_matrix", bus.matrix_out, 0);
    checkOutput("mid_rst_size", bus.matrix_size, 0);
    checkOutput("mid_rst_out_valid", bus.out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 2'b00, 0, 1, 8'h55, 0);
    applyStimulus(0, 2'b00, 0, 1, 8'h55, 0);
    checkOutput("post_rst_in_ready", bus.in_ready, 0);
    checkOutput("post_rst_matrix", bus.matrix_out, 0);

    // 2x2 back-to-back, out_valid timing
    applyStimulus(1, 2'b00, 0, 0, 8'h00, 0);
    checkOutput("t0_in_ready", bus.in_ready, 1);
    applyStimulus(0, 2'b00, 0, 1, 8'h01, 0);
    applyStimulus(0, 2'b00, 0, 1, 8'hFF, 0);
    applyStimulus(0, 2'b00, 0, 1, 8'h7F, 0);
    checkOutput("t3_out_valid", bus.out_valid, 0);
    applyStimulus(0, 2'b00, 0, 1, 8'h80, 0);
    checkOutput("t4_out_valid", bus.out_valid, 1);
    checkOutput("t4_in_ready", bus.in_ready, 0);
    checkOutput("x2_matrix", bus.matrix_out, {168'b0, 32'h807FFF01});
    checkOutput("x2_size", bus.matrix_size, 2'b00);
    applyStimulus(0, 2'b00, 0, 0, 8'h00, 1);
    checkOutput("x2_handshake_valid", bus.out_valid, 0);
    checkOutput("x2_handshake_busy", busy, 0);

    // 5x5 with a bubble every third cycle
    applyStimulus(1, 2'b11, 0, 0, 8'h00, 0);
    exp_mat = '0;
    k = 0;
    early = 1'b0;
    for (int c = 0; c < 100 && k < 25; c++) begin
      if (bus.out_valid) early = 1'b1;
      v = ((c % 3) != 2);
      applyStimulus(0, 2'b00, 0, v, 8'(k + 1), 0);
      if (v) begin
        exp_mat[k*8 +: 8] = 8'(k + 1);
        k++;
      end
    end
    checkOutput("x5_early_valid", early, 0);
    checkOutput("x5_accepts", k, 25);
    checkOutput("x5_out_valid", bus.out_valid, 1);
    checkOutput("x5_matrix", bus.matrix_out, exp_mat);
    checkOutput("x5_size", bus.matrix_size, 2'b11);
    applyStimulus(0, 2'b00, 0, 0, 8'h00, 1);
    checkOutput("x5_handshake", bus.out_valid, 0);

    // 3x3 held with out_ready low while start and in_valid are active
    applyStimulus(1, 2'b01, 0, 0, 8'h00, 0);
    exp_mat = '0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 2'b00, 0, 1, 8'(8'h10 + i), 0);
      exp_mat[i*8 +: 8] = 8'(8'h10 + i);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 2'b00, 0, 1, 8'hEE, 0);
      checkOutput("hold_valid", bus.out_valid, 1);
      checkOutput("hold_in_ready", bus.in_ready, 0);
      checkOutput("hold_matrix", bus.matrix_out, exp_mat);
    end
    checkOutput("hold_size", bus.matrix_size, 2'b01);
    applyStimulus(1, 2'b10, 1, 1, 8'hEE, 1);
    checkOutput("hold_exit_valid", bus.out_valid, 0);
    checkOutput("hold_exit_busy", busy, 0);
    applyStimulus(0, 2'b00, 0, 0, 8'h00, 0);
    checkOutput("hold_start_ignored", bus.in_ready, 0);
    checkOutput("hold_size_kept", bus.matrix_size, 2'b01);

    // 4x4 aborted on the 6th element
    applyStimulus(1, 2'b10, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 2'b00, 0, 1, 8'(8'h61 + i), 0);
    checkOutput("abort_pre_matrix", bus.matrix_out, {160'b0, 40'h6564636261});
    applyStimulus(0, 2'b00, 1, 1, 8'h66, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_in_ready", bus.in_ready, 0);
    checkOutput("abort_matrix", bus.matrix_out, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 2'b00, 0, 1, 8'h77, 0);
      checkOutput("abort_no_valid", bus.out_valid, 0);
    end

    // 3x3 then 2x2 back to back; stale elements must be cleared
    applyStimulus(1, 2'b01, 0, 0, 8'h00, 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 2'b00, 0, 1, 8'(8'h21 + i), 0);
    checkOutput("b2b_first", bus.matrix_out, {128'b0, 72'h292827262524232221});
    applyStimulus(0, 2'b00, 0, 0, 8'h00, 1);
    applyStimulus(1, 2'b00, 0, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 2'b00, 0, 1, 8'(8'h31 + i), 0);
    checkOutput("b2b_valid", bus.out_valid, 1);
    checkOutput("b2b_second", bus.matrix_out, {168'b0, 32'h34333231});
    checkOutput("b2b_size", bus.matrix_size, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
